// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, optional skid entry,
// synchronous flush, load extraction and final write-back selection.
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_we,
    output logic [RA_W-1:0] out_rd,
    output logic [XLEN-1:0] out_wb_data,
    output logic            fwd_valid
);

    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;

    logic            main_valid;
    logic            main_we;
    logic [RA_W-1:0] main_rd;
    logic [XLEN-1:0] main_data;
    logic            skid_valid;
    logic            skid_we;
    logic [RA_W-1:0] skid_rd;
    logic [XLEN-1:0] skid_data;

    logic            acc;
    logic            drain;

    assign off = in_alu_result[1:0];

    always_comb begin
        ld_byte = in_mem_rdata[7:0];
        case (off)
            2'd1:    ld_byte = in_mem_rdata[15:8];
            2'd2:    ld_byte = in_mem_rdata[23:16];
            2'd3:    ld_byte = in_mem_rdata[31:24];
            default: ld_byte = in_mem_rdata[7:0];
        endcase
        ld_half = off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    end

    always_comb begin
        ld_data = XLEN'($signed(in_mem_rdata[31:0]));
        case (in_funct3)
            3'b000:  ld_data = XLEN'($signed(ld_byte));
            3'b001:  ld_data = XLEN'($signed(ld_half));
            3'b100:  ld_data = XLEN'(ld_byte);
            3'b101:  ld_data = XLEN'(ld_half);
            default: ld_data = XLEN'($signed(in_mem_rdata[31:0]));
        endcase
    end

    always_comb begin
        wb_data = in_alu_result;
        unique case (1'b1)
            (in_wb_sel == 2'b01): wb_data = ld_data;
            (in_wb_sel == 2'b10): wb_data = in_pc_plus4;
            default:              wb_data = in_alu_result;
        endcase
    end

    // x0 keeps its rd/data but never asserts a write
    assign wb_we = in_reg_write & (in_rd != '0);

    assign in_ready = (SKID != 0) ? ~skid_valid
                                  : (out_ready | ~main_valid);
    assign acc   = in_valid & in_ready;
    assign drain = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_we    <= 1'b0;
            main_rd    <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_we    <= 1'b0;
            skid_rd    <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_we    <= skid_we;
                main_rd    <= skid_rd;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (acc) begin
                main_valid <= 1'b1;
                main_we    <= wb_we;
                main_rd    <= in_rd;
                main_data  <= wb_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (acc && SKID != 0) begin
            skid_valid <= 1'b1;
            skid_we    <= wb_we;
            skid_rd    <= in_rd;
            skid_data  <= wb_data;
        end
    end

    assign out_valid   = main_valid;
    assign out_we      = main_valid & main_we;
    assign out_rd      = main_rd;
    assign out_wb_data = main_data;
    assign fwd_valid   = out_we;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed plan items plus
// randomized traffic against a field-level reference model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_wb_data;
    logic        fwd_valid;

    mem_wb_stage #(.XLEN(32), .RA_W(5), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .out_valid(out_valid),
        .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd),
        .out_wb_data(out_wb_data), .fwd_valid(fwd_valid)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] alu,
                                          input logic [31:0] rdata,
                                          input logic [31:0] pc4,
                                          input logic [1:0]  sel,
                                          input logic [2:0]  f3);
        int unsigned b, h, ld;
        b = (rdata >> ((alu % 4) * 8)) % 256;
        h = (rdata >> (((alu / 2) % 2) * 16)) % 65536;
        case (f3)
            3'd0:    ld = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    ld = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    ld = b;
            3'd5:    ld = h;
            default: ld = rdata;
        endcase
        if (sel == 2'd1) return ld;
        if (sel == 2'd2) return pc4;
        return alu;
    endfunction

    task automatic step(input logic v, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic rw,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic ordy, input logic fl);
        exp_t e;
        @(negedge clk);
        in_valid      = v;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_pc_plus4   = pc4;
        in_rd         = rd;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_funct3     = f3;
        out_ready     = ordy;
        flush         = fl;
        if (v && in_ready && !fl && rst_n) begin
            e.d  = model(alu, rdata, pc4, sel, f3);
            e.rd = rd;
            e.we = rw && (rd != 0);
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 0, 0, 0, 0, 1'b0, 2'd0, 3'd2, 1'b1, 1'b0);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] d,
                          input logic ordy);
        step(1'b1, d, 32'h0, 32'h0, rd, 1'b1, 2'd0, 3'd2, ordy, 1'b0);
    endtask

    task automatic load_chk(input string name, input logic [1:0] off,
                            input logic [2:0] f3, input logic [31:0] exp);
        step(1'b1, {30'h40, off}, 32'h80FF7F01, 32'h0, 5'd7, 1'b1,
             2'd1, f3, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk(name, out_wb_data, exp);
    endtask

    // Monitor: pops and compares on every completed out handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got rd %0d data %h want none",
                                 out_rd, out_wb_data);
                    end else begin
                        e = q.pop_front();
                        chk("sb_data", out_wb_data, e.d);
                        chk("sb_rd", {27'h0, out_rd}, {27'h0, e.rd});
                        chk("sb_we", {31'h0, out_we}, {31'h0, e.we});
                        chk("sb_fwd", {31'h0, fwd_valid}, {31'h0, e.we});
                    end
                end else if (out_valid && q.size() > 0) begin
                    chk("fwd_hold", {31'h0, fwd_valid}, {31'h0, q[0].we});
                end
                if (flush) q.delete();
            end
        end
    end

    initial begin
        int c;
        rst_n = 1'b0;
        in_valid = 0; in_alu_result = 0; in_mem_rdata = 0; in_pc_plus4 = 0;
        in_rd = 0; in_reg_write = 0; in_wb_sel = 0; in_funct3 = 0;
        out_ready = 1'b1; flush = 1'b0;
        #2;
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_we", {31'h0, out_we}, 0);
        chk("rst_fwd", {31'h0, fwd_valid}, 0);
        chk("rst_rd", {27'h0, out_rd}, 0);
        chk("rst_data", out_wb_data, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'h0, in_ready}, 1);

        for (int i = 1; i <= 4; i++) begin
            alu_op(i[4:0], 32'h10 + i - 1, 1'b1);
            @(posedge clk); #1;
            chk("stream_valid", {31'h0, out_valid}, 1);
            chk("stream_rd", {27'h0, out_rd}, i);
            chk("stream_data", out_wb_data, 32'h10 + i - 1);
            chk("stream_we", {31'h0, out_we}, 1);
        end
        idle(2);

        load_chk("lb0", 2'd0, 3'd0, 32'h00000001);
        load_chk("lb1", 2'd1, 3'd0, 32'h0000007F);
        load_chk("lb2", 2'd2, 3'd0, 32'hFFFFFFFF);
        load_chk("lb3", 2'd3, 3'd0, 32'hFFFFFF80);
        load_chk("lbu3", 2'd3, 3'd4, 32'h00000080);
        load_chk("lh2", 2'd2, 3'd1, 32'hFFFF80FF);
        load_chk("lhu0", 2'd0, 3'd5, 32'h00007F01);
        load_chk("lw", 2'd0, 3'd2, 32'h80FF7F01);
        idle(2);

        alu_op(5'd0, 32'h55, 1'b1);
        @(posedge clk); #1;
        chk("x0_valid", {31'h0, out_valid}, 1);
        chk("x0_we", {31'h0, out_we}, 0);
        chk("x0_fwd", {31'h0, fwd_valid}, 0);
        step(1'b1, 32'h99, 32'h0, 32'h104, 5'd1, 1'b1, 2'd2, 3'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("link_data", out_wb_data, 32'h104);
        idle(2);

        alu_op(5'd10, 32'hA0, 1'b0);
        @(posedge clk); #1;
        chk("bp_ready1", {31'h0, in_ready}, 1);
        alu_op(5'd11, 32'hA1, 1'b0);
        @(posedge clk); #1;
        chk("bp_ready2", {31'h0, in_ready}, 0);
        alu_op(5'd12, 32'hA2, 1'b0);
        @(posedge clk); #1;
        chk("bp_head", {27'h0, out_rd}, 10);
        alu_op(5'd13, 32'hA3, 1'b1);
        alu_op(5'd14, 32'hA4, 1'b1);
        alu_op(5'd15, 32'hA5, 1'b1);
        idle(3);

        alu_op(5'd20, 32'hB0, 1'b0);
        alu_op(5'd21, 32'hB1, 1'b0);
        step(1'b1, 32'hDEAD, 0, 0, 5'd22, 1'b1, 2'd0, 3'd2, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("flush_valid", {31'h0, out_valid}, 0);
        chk("flush_ready", {31'h0, in_ready}, 1);
        alu_op(5'd23, 32'hB3, 1'b1);
        idle(3);

        alu_op(5'd24, 32'hC0, 1'b0);
        alu_op(5'd25, 32'hC1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 0);
        chk("arst_we", {31'h0, out_we}, 0);
        chk("arst_fwd", {31'h0, fwd_valid}, 0);
        chk("arst_rd", {27'h0, out_rd}, 0);
        chk("arst_data", out_wb_data, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
        end

        c = 0;
        while (q.size() != 0 && c < 20) begin
            idle(1);
            c++;
        end
        idle(1);
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
